controlador_entrada_saida: RTL and testbench
============================================

Name: controlador_entrada_saida

Overview:
Sequencing controller for the processor's `in`, `out` and `hlt` instructions.
- Sits between the control unit's decoded in/out/hlt strobes and the board I/O (switches, confirm button, display).
- Stalls the PC and register-file enables while an `in` waits for a debounced user confirm.
- Delivers the captured switch value with a one-cycle write strobe.
- Latches `out` values to the display.
- Freezes the core permanently on `hlt`.

Parameters:
DATA_W, 32, datapath/register width
SW_W, 16, switch bank width (SW_W <= DATA_W)
DEB_CYCLES, 4, consecutive synchronized-high cycles required to accept a press (>= 1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_req  input  1  control unit `in` strobe, level, held while instruction is current
out_req  input  1  control unit `out` strobe, level
hlt  input  1  control unit `hlt` strobe
out_data  input  DATA_W  register value to display
switches  input  SW_W  raw switch bank, sampled only at capture
btn_confirm  input  1  raw asynchronous confirm button, active-high
stall  output  1  1 = hold PC and suppress register/memory writes
in_data  output  DATA_W  captured switches, zero-extended
in_valid  output  1  one-cycle register-write strobe for in_data
display  output  DATA_W  latched output value
waiting_input  output  1  LED: controller is waiting for confirm
halted  output  1  core halted

Behaviour:
- Reset values: all registered outputs 0; state IDLE; debounce counter 0; both sync flops 0.
- Button synchronizer:
  - btn_confirm passes through 2 flops to give btn_s.
  - FSM uses btn_s only; 2-cycle latency.
- States: IDLE, WAIT_RELEASE, WAIT_PRESS, DEBOUNCE, DONE, HALT.
- IDLE:
  - Priority is hlt > in_req > out_req.
  - hlt: go to HALT.
  - in_req: go to WAIT_RELEASE.
  - out_req: display <= out_data on that edge; stay IDLE.
- WAIT_RELEASE: btn_s==0 goes to WAIT_PRESS. This prevents a held button satisfying back-to-back `in` instructions.
- WAIT_PRESS: btn_s==1 goes to DEBOUNCE, counter <= 0.
- DEBOUNCE:
  - btn_s==0: return to WAIT_PRESS (bounce rejected).
  - btn_s==1 and counter==DEB_CYCLES-1: in_data <= {zeros, switches}, go to DONE.
  - btn_s==1 otherwise: counter++.
  - DEBOUNCE therefore occupies exactly DEB_CYCLES cycles on a clean press.
- DONE:
  - One cycle; in_valid=1 and stall=0 so PC advances and the register write occurs on the same edge.
  - Next state is IDLE unconditionally.
- HALT: absorbing; only reset leaves it.
- Output decode:
  - stall is combinational:
    - 1 in IDLE when (in_req | hlt).
    - 1 in WAIT_RELEASE, WAIT_PRESS, DEBOUNCE and HALT.
    - 0 in DONE, and 0 in IDLE otherwise.
    - The stall covers the issuing cycle of an `in` or `hlt` instruction.
  - waiting_input = (state in WAIT_RELEASE, WAIT_PRESS, DEBOUNCE).
  - halted = (state==HALT).
  - in_valid = (state==DONE).
- in_data and display hold their values until the next capture or latch.
- out_req in any non-IDLE state is ignored. It cannot legally occur, since the core is stalled.
- in_req and out_req together: `in` wins; display is unchanged.
- Press-to-write latency on a clean press in WAIT_PRESS: 2 (sync) + 1 (WAIT_PRESS to DEBOUNCE) + DEB_CYCLES, then in_valid in the following cycle.
- Reset mid-operation, in any state: returns to IDLE next edge. No in_valid pulse; display and in_data cleared.

Test Plan:
1. Reset asserted 3 cycles with random inputs -> stall, in_valid, in_data, display, waiting_input, halted all 0 after the reset edge.
2. in_req=1, btn low, switches=16'h00A5, clean press at cycle 10 held 20 cycles:
   - stall=1 from cycle 0.
   - waiting_input=1 from cycle 1.
   - in_valid exactly one pulse 8 cycles after btn rise, with in_data=32'h000000A5.
   - stall=0 in that same cycle.
3. Bounce: btn high 2 cycles, low 1, high 2, low 1, then stable high -> no in_valid until 4 consecutive btn_s-high cycles; then exactly one pulse.
4. Back-to-back `in` with button still held from the previous capture -> controller remains in WAIT_RELEASE, stall=1, no in_valid until release and fresh press; second capture reflects switches=16'hFFFF -> in_data=32'h0000FFFF.
5. out_req=1, out_data=32'h00001234 for one cycle in IDLE -> display=32'h00001234 next cycle, stall never 1. Then hlt=1 with out_req=1 and out_data=32'hDEAD -> halted=1, stall=1, display stays 32'h00001234.
6. hlt pulse one cycle -> halted and stall remain 1 for 100 cycles regardless of inputs. Separately, reset during DEBOUNCE (counter=2) -> IDLE next edge, in_valid never pulses.

Source files
------------

// File: rtl/controlador_entrada_saida_if.sv
// Bundle of control-unit strobes, board I/O and core-facing results for the in/out/hlt
// sequencer. The master side is the core plus board; the slave side is the controller.
interface controlador_entrada_saida_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SW_W   = 16
);
  logic              in_req;
  logic              out_req;
  logic              hlt;
  logic [DATA_W-1:0] out_data;
  logic [SW_W-1:0]   switches;
  logic              btn_confirm;

  logic              stall;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] display;
  logic              waiting_input;
  logic              halted;

  modport master (
    output in_req,
    output out_req,
    output hlt,
    output out_data,
    output switches,
    output btn_confirm,
    input  stall,
    input  in_data,
    input  in_valid,
    input  display,
    input  waiting_input,
    input  halted
  );

  modport slave (
    input  in_req,
    input  out_req,
    input  hlt,
    input  out_data,
    input  switches,
    input  btn_confirm,
    output stall,
    output in_data,
    output in_valid,
    output display,
    output waiting_input,
    output halted
  );
endinterface

// File: rtl/controlador_entrada_saida.sv
// Sequencer for the in/out/hlt instructions: stalls the core while an `in` waits for a
// synchronized, debounced confirm press, latches `out` values and freezes the core on `hlt`.
module controlador_entrada_saida #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SW_W       = 16,
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic                        clock,
  input logic                        reset,
  controlador_entrada_saida_if.slave bus_io
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StWaitRelease = 3'd1;
  localparam logic [2:0] StWaitPress   = 3'd2;
  localparam logic [2:0] StDebounce    = 3'd3;
  localparam logic [2:0] StDone        = 3'd4;
  localparam logic [2:0] StHalt        = 3'd5;

  if (SW_W > DATA_W) begin : gen_bad_sw_w
    $error("SW_W must not exceed DATA_W");
  end
  if (DEB_CYCLES < 1) begin : gen_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              btn_meta_q;
  logic              btn_s_q;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic [DATA_W-1:0] display_q, display_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      in_data_q  <= '0;
      display_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_meta_q <= bus_io.btn_confirm;
      btn_s_q    <= btn_meta_q;
      in_data_q  <= in_data_d;
      display_q  <= display_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_data_d = in_data_q;
    display_d = display_q;
    case (state_q)
      StIdle: begin
        if (bus_io.hlt) begin
          state_d = StHalt;
        end else if (bus_io.in_req) begin
          state_d = StWaitRelease;
        end else if (bus_io.out_req) begin
          display_d = bus_io.out_data;
        end
      end
      // A button still held from the previous capture must be released first.
      StWaitRelease: begin
        if (!btn_s_q) begin
          state_d = StWaitPress;
        end
      end
      StWaitPress: begin
        if (btn_s_q) begin
          state_d = StDebounce;
          cnt_d   = '0;
        end
      end
      StDebounce: begin
        if (!btn_s_q) begin
          state_d = StWaitPress;
        end else if (cnt_q == CntLast) begin
          in_data_d = DATA_W'(bus_io.switches);
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus_io.stall         = 1'b0;
    bus_io.waiting_input = 1'b0;
    bus_io.halted        = 1'b0;
    bus_io.in_valid      = 1'b0;
    case (state_q)
      // The issuing cycle of an `in` or `hlt` is already stalled.
      StIdle: bus_io.stall = bus_io.in_req | bus_io.hlt;
      StWaitRelease, StWaitPress, StDebounce: begin
        bus_io.stall         = 1'b1;
        bus_io.waiting_input = 1'b1;
      end
      StDone: bus_io.in_valid = 1'b1;
      StHalt: begin
        bus_io.stall  = 1'b1;
        bus_io.halted = 1'b1;
      end
      default: bus_io.stall = 1'b0;
    endcase
  end

  assign bus_io.in_data = in_data_q;
  assign bus_io.display = display_q;

  assert property (@(posedge clock) disable iff (reset) bus_io.in_valid |-> !bus_io.stall);
  assert property (@(posedge clock) disable iff (reset) bus_io.halted |=> bus_io.halted);

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Directed bench for the in/out/hlt sequencer with a cycle-level reference model.
module tb_controlador_entrada_saida;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SW_W   = 16;
  localparam int unsigned DEB    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controlador_entrada_saida_if #(.DATA_W(DATA_W), .SW_W(SW_W)) bus_if ();

  controlador_entrada_saida #(
    .DATA_W    (DATA_W),
    .SW_W      (SW_W),
    .DEB_CYCLES(DEB)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus_io(bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an `in` completes once DEB+1 consecutive synchronized-high samples
  // are seen after the button has been observed released.
  bit          m_valid = 1'b0;
  bit          m_halt, m_busy, m_armed, m_done, m_s1, m_s2, m_bs, m_idle, m_stall;
  int          m_run;
  logic [31:0] m_in_data, m_disp;

  always @(negedge clk) begin
    if (m_valid) begin
      m_idle  = !m_halt && !m_busy && !m_done;
      m_stall = m_halt || m_busy || (m_idle && (bus_if.in_req || bus_if.hlt));
      check("stall", 32'(bus_if.stall), 32'(m_stall));
      check("in_valid", 32'(bus_if.in_valid), 32'(m_done));
      check("waiting_input", 32'(bus_if.waiting_input), 32'(m_busy));
      check("halted", 32'(bus_if.halted), 32'(m_halt));
      check("in_data", bus_if.in_data, m_in_data);
      check("display", bus_if.display, m_disp);
    end
    m_bs = m_s2;
    if (rst) begin
      m_valid = 1'b1;
      {m_halt, m_busy, m_armed, m_done, m_s1, m_s2} = '0;
      m_run = 0;
      m_in_data = '0;
      m_disp = '0;
    end else begin
      m_s2 = m_s1;
      m_s1 = bus_if.btn_confirm;
      if (m_halt) begin
        m_halt = 1'b1;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_busy) begin
        if (!m_armed) begin
          m_armed = !m_bs;
        end else if (!m_bs) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == DEB + 1) begin
            m_in_data = 32'(bus_if.switches);
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (bus_if.hlt) begin
        m_halt = 1'b1;
      end else if (bus_if.in_req) begin
        m_busy = 1'b1;
        m_armed = 1'b0;
        m_run = 0;
      end else if (bus_if.out_req) begin
        m_disp = bus_if.out_data;
      end
    end
  end

  logic        obs_stall[64];
  logic        obs_wait[64];
  int          first_pulse;
  int          n_pulse;
  logic [31:0] pulse_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_pat(input int lo, input int hi);
    logic [63:0] p = '0;
    for (int i = lo; i <= hi && i < 64; i++) p[i] = 1'b1;
    return p;
  endfunction

  // Cycle i drives btn_confirm = pat[i]; the `in` strobe drops once its write is seen.
  task automatic run_cycles(input int n, input logic [63:0] pat);
    first_pulse = -1;
    n_pulse = 0;
    pulse_data = '0;
    for (int i = 0; i < n; i++) begin
      bus_if.btn_confirm = pat[i];
      #1;
      obs_stall[i] = bus_if.stall;
      obs_wait[i]  = bus_if.waiting_input;
      if (bus_if.in_valid) begin
        n_pulse++;
        if (first_pulse < 0) begin
          first_pulse = i;
          pulse_data = bus_if.in_data;
        end
        bus_if.in_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic clear_inputs();
    bus_if.in_req = 1'b0;
    bus_if.out_req = 1'b0;
    bus_if.hlt = 1'b0;
    bus_if.out_data = '0;
    bus_if.switches = '0;
    bus_if.btn_confirm = 1'b0;
  endtask

  task automatic random_inputs();
    bus_if.in_req = 1'($urandom);
    bus_if.out_req = 1'($urandom);
    bus_if.hlt = 1'($urandom);
    bus_if.out_data = $urandom;
    bus_if.switches = 16'($urandom);
    bus_if.btn_confirm = 1'($urandom);
  endtask

  int halt_good;

  initial begin
    // 1: reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      @(posedge clk);
      #1;
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(bus_if.stall), 32'h0);
    check("rst_in_valid", 32'(bus_if.in_valid), 32'h0);
    check("rst_in_data", bus_if.in_data, 32'h0);
    check("rst_display", bus_if.display, 32'h0);
    check("rst_waiting", 32'(bus_if.waiting_input), 32'h0);
    check("rst_halted", 32'(bus_if.halted), 32'h0);

    // 2: clean press raised in cycle 10, held 20 cycles
    bus_if.in_req = 1'b1;
    bus_if.switches = 16'h00A5;
    run_cycles(40, mk_pat(10, 29));
    check("t2_stall_c0", 32'(obs_stall[0]), 32'h1);
    check("t2_wait_c0", 32'(obs_wait[0]), 32'h0);
    check("t2_wait_c1", 32'(obs_wait[1]), 32'h1);
    // 8th cycle counting the rise cycle as the first
    check("t2_pulse_cycle", 32'(first_pulse), 32'd17);
    check("t2_pulse_count", 32'(n_pulse), 32'd1);
    check("t2_in_data", pulse_data, 32'h000000A5);
    check("t2_stall_done", 32'(obs_stall[17]), 32'h0);
    check("t2_stall_pre", 32'(obs_stall[16]), 32'h1);

    // 3: bouncing press, stable from cycle 11
    bus_if.in_req = 1'b1;
    bus_if.switches = 16'h5A3C;
    run_cycles(30, mk_pat(5, 6) | mk_pat(8, 9) | mk_pat(11, 63));
    check("t3_pulse_cycle", 32'(first_pulse), 32'd18);
    check("t3_pulse_count", 32'(n_pulse), 32'd1);
    check("t3_in_data", pulse_data, 32'h00005A3C);

    // 4: back-to-back `in` with the button still held; simultaneous out_req loses
    bus_if.in_req = 1'b1;
    bus_if.out_req = 1'b1;
    bus_if.out_data = 32'h0000BEEF;
    bus_if.switches = 16'hFFFF;
    run_cycles(1, 64'h1);
    bus_if.out_req = 1'b0;
    check("t4_stall_c0", 32'(obs_stall[0]), 32'h1);
    run_cycles(30, mk_pat(0, 8) | mk_pat(14, 63));
    check("t4_wait_held", 32'(obs_wait[3]), 32'h1);
    check("t4_stall_held", 32'(obs_stall[8]), 32'h1);
    check("t4_pulse_cycle", 32'(first_pulse), 32'd21);
    check("t4_pulse_count", 32'(n_pulse), 32'd1);
    check("t4_in_data", pulse_data, 32'h0000FFFF);
    check("t4_display", bus_if.display, 32'h0);

    // 5: out latch, then hlt with a competing out
    bus_if.btn_confirm = 1'b0;
    bus_if.out_req = 1'b1;
    bus_if.out_data = 32'h00001234;
    #1;
    check("t5_out_stall", 32'(bus_if.stall), 32'h0);
    step();
    bus_if.out_req = 1'b0;
    #1;
    check("t5_display", bus_if.display, 32'h00001234);
    check("t5_stall_after", 32'(bus_if.stall), 32'h0);
    bus_if.hlt = 1'b1;
    bus_if.out_req = 1'b1;
    bus_if.out_data = 32'h0000DEAD;
    #1;
    check("t5_hlt_stall", 32'(bus_if.stall), 32'h1);
    step();
    bus_if.hlt = 1'b0;
    bus_if.out_req = 1'b0;
    #1;
    check("t5_halted", 32'(bus_if.halted), 32'h1);
    check("t5_stall", 32'(bus_if.stall), 32'h1);
    check("t5_display_kept", bus_if.display, 32'h00001234);

    // 6a: halt is absorbing
    halt_good = 0;
    for (int i = 0; i < 100; i++) begin
      random_inputs();
      #1;
      if (bus_if.halted && bus_if.stall) halt_good++;
      step();
    end
    check("t6_halt_hold", 32'(halt_good), 32'd100);

    // 6b: reset in the middle of debounce
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_unhalt", 32'(bus_if.halted), 32'h0);
    bus_if.out_req = 1'b1;
    bus_if.out_data = 32'h000055AA;
    step();
    bus_if.out_req = 1'b0;
    bus_if.in_req = 1'b1;
    bus_if.switches = 16'h0F0F;
    run_cycles(15, mk_pat(10, 63));
    check("t6_in_debounce", 32'(bus_if.waiting_input), 32'h1);
    check("t6_display_pre", bus_if.display, 32'h000055AA);
    rst = 1'b1;
    bus_if.in_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("t6_wait_clr", 32'(bus_if.waiting_input), 32'h0);
    check("t6_stall_clr", 32'(bus_if.stall), 32'h0);
    check("t6_valid_clr", 32'(bus_if.in_valid), 32'h0);
    check("t6_display_clr", bus_if.display, 32'h0);
    check("t6_in_data_clr", bus_if.in_data, 32'h0);
    run_cycles(20, {64{1'b1}});
    check("t6_no_pulse", 32'(n_pulse), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
